vga_ctrl_param: RTL and testbench
=================================

# vga_ctrl_param

Parametrised VGA timing and pixel-output controller, the successor to the fixed 640x480 / RGB565 `vga_ctrl`. It generates the horizontal and vertical counters and the sync, data-enable and RGB outputs for any timing set and any per-channel colour width. It issues pixel requests `PIX_LAT` cycles ahead so upstream pixel generators with pipeline latency line up with the active window. A frame-synchronous built-in colour-bar test pattern is included.

## Interface
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch
- `H_ACT`, 640, horizontal active pixels
- `H_FP`, 16, horizontal front porch
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch
- `V_ACT`, 480, vertical active lines
- `V_FP`, 10, vertical front porch
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level
- `R_W` / `G_W` / `B_W`, 5 / 6 / 5, channel widths; `RGB_W = R_W+G_W+B_W`
- `CNT_W`, 12, counter and coordinate width
- `PIX_LAT`, 1, upstream latency from `pix_req` to valid `pix_data`; 0 ≤ `PIX_LAT` ≤ `H_SYNC+H_BP`
- `vga_clk`  in  1  pixel clock
- `sys_rst_n`  in  1  reset; one clock, asynchronous, active-low
- `pix_data`  in  RGB_W  pixel from upstream, `{R,G,B}`
- `test_en`  in  1  selects colour-bar pattern instead of `pix_data`
- `pix_req`  out  1  request for pixel (`pix_x`, `pix_y`)
- `pix_x`  out  CNT_W  requested column; all-ones when `pix_req`=0
- `pix_y`  out  CNT_W  requested row; all-ones when `pix_req`=0
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `de`  out  1  active-video data enable
- `rgb`  out  RGB_W  output pixel; zero outside active
- `frame_start`  out  1  one-cycle pulse aligned with the first output cycle of a frame

## Operation
- `cnt_h` runs 0..H_TOT-1 and wraps, with `H_TOT = H_SYNC+H_BP+H_ACT+H_FP`. `cnt_v` increments when `cnt_h` wraps and itself wraps at `V_TOT-1`.
- Region order per line and per frame: sync, back porch, active, front porch. Define `H_ST = H_SYNC+H_BP` and `V_ST = V_SYNC+V_BP`.
- Active: `H_ST ≤ cnt_h < H_ST+H_ACT` and `V_ST ≤ cnt_v < V_ST+V_ACT`.
- `pix_req` (combinational from the counters) asserts when `V_ST ≤ cnt_v < V_ST+V_ACT` and `H_ST-PIX_LAT ≤ cnt_h < H_ST+H_ACT-PIX_LAT`.
  - While asserted: `pix_x = cnt_h-(H_ST-PIX_LAT)` and `pix_y = cnt_v-V_ST`.
- `pix_data` is sampled in the counter cycle that is `PIX_LAT` cycles after its request, i.e. the counter cycle that is active for that `x`.
- Registered outputs at each edge:
  - `hsync = (cnt_h<H_SYNC) ? H_POL : !H_POL`; `vsync` likewise using `cnt_v`.
  - `de` = active.
  - `rgb` = active ? (`test_sel` ? bar : `pix_data`) : 0.
  - `frame_start` = (`cnt_h`==0 && `cnt_v`==0).
- `test_sel` captures `test_en` only when `cnt_h`==0 && `cnt_v`==0. A change of `test_en` mid-frame takes effect at the next frame.
- Colour bars: active width divided into 8 equal bars, bar k covering x in [k·H_ACT/8, (k+1)·H_ACT/8).
  - Sequence: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones or zero.
  - Boundaries are compared against elaborated constants; no divider.

## Timing
- Reset values: counters 0, `hsync` = !H_POL, `vsync` = !V_POL, `de` 0, `rgb` 0, `frame_start` 0, `test_sel` 0.
- Reset assertion mid-frame forces these values immediately (asynchronous). Release restarts at (0,0).
- `frame_start` pulses on the first edge after reset release.
- `hsync`/`vsync`/`de`/`rgb`/`frame_start`: 1-cycle latency from the counter state.
- `pix_req`/`pix_x`/`pix_y`: 0-cycle latency from the counter state.
- The request window never crosses a line boundary because of the `PIX_LAT` bound. Out-of-range parameters are an elaboration error.
- Line period `H_TOT` clocks; frame period `H_TOT·V_TOT` clocks.

## Structure
- Package `vga_pkg`:
  - Timing sets `VGA_640x480_60` (96/48/640/16, 2/33/480/10, negative polarity).
  - Timing set `SVGA_800x600_60` (128/88/800/40, 4/23/600/1, positive polarity).
  - Bar colour constants.
  - Helper function for the bar boundaries.
- Sub-module `vga_color_bar` (x → `RGB_W` bar colour, combinational). Counters and output registers live in the top.

## Test plan
Small-timing bench: H 4/4/16/4 (H_TOT=28), V 2/2/4/2 (V_TOT=10), RGB565.
- Reset, hold 5 cycles:
  - `hsync`=`vsync`=1, `de`=0, `rgb`=0.
  - `pix_x`=`pix_y`=0xFFF.
  - First edge after release gives `frame_start`=1 for exactly one cycle, then again every 280 cycles.
- Default 640x480:
  - `hsync` low 96 of every 800 cycles.
  - `vsync` low 1600 of every 420000 cycles.
  - `de` high 640 cycles per line on 480 lines.
- `PIX_LAT`=3, upstream delays `pix_x` by 3 as `pix_data`:
  - `pix_req` first at `cnt_h`=5 with `pix_x`=0.
  - `de` rises the edge after `cnt_h`=8.
  - `rgb` carries 0..15 in order with `de` high for exactly 16 cycles.
- `test_en` raised mid-frame:
  - Current frame still shows `pix_data`.
  - Next frame: `rgb` pixels 0–1 = 0xFFFF, 2–3 = 0xFFE0, 12–13 = 0x001F, 14–15 = 0x0000.
- `H_POL`=1, `V_POL`=1: `hsync` high for 4 cycles per line, `vsync` high for 2 lines per frame.
- `sys_rst_n` pulsed low at `cnt_h`=12, `cnt_v`=5:
  - `de`/`rgb` drop to 0 without waiting for a clock edge.
  - After release the counters restart at (0,0), and `frame_start` pulses on the first edge after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing sets, colour-bar palette and the bar boundary helper.
// Imported by the parametrised controller and its colour-bar generator.
package vga_pkg;

    typedef struct packed {
        int   h_sync;
        int   h_bp;
        int   h_act;
        int   h_fp;
        int   v_sync;
        int   v_bp;
        int   v_act;
        int   v_fp;
        logic h_pol;
        logic v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_sync: 96, h_bp: 48, h_act: 640, h_fp: 16,
        v_sync: 2,  v_bp: 33, v_act: 480, v_fp: 10,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_timing_t SVGA_800x600_60 = '{
        h_sync: 128, h_bp: 88, h_act: 800, h_fp: 40,
        v_sync: 4,   v_bp: 23, v_act: 600, v_fp: 1,
        h_pol: 1'b1, v_pol: 1'b1
    };

    // Bar colours as {R,G,B} on/off masks; each channel is all-ones or zero.
    typedef enum logic [2:0] {
        BAR_BLACK   = 3'b000,
        BAR_BLUE    = 3'b001,
        BAR_GREEN   = 3'b010,
        BAR_CYAN    = 3'b011,
        BAR_RED     = 3'b100,
        BAR_MAGENTA = 3'b101,
        BAR_YELLOW  = 3'b110,
        BAR_WHITE   = 3'b111
    } bar_color_e;

    function automatic bar_color_e bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    // Left edge of bar k; only ever evaluated on constants at elaboration.
    function automatic int bar_edge(input int h_act, input int k);
        return (k * h_act) / 8;
    endfunction

endpackage

// File: rtl/vga_color_bar.sv
// Combinational colour-bar generator: active-window column in, bar colour out.
// Boundaries are elaboration-time constants, so only comparators are built.
module vga_color_bar
    import vga_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int R_W   = 5,
    parameter int G_W   = 6,
    parameter int B_W   = 5,
    parameter int CNT_W = 12
) (
    input  logic [CNT_W-1:0]         x,
    output logic [R_W+G_W+B_W-1:0]   color
);

    logic [7:1] past_edge;
    logic [2:0] idx;
    logic [2:0] mask;

    for (genvar k = 1; k < 8; k++) begin : g_edge
        localparam logic [CNT_W-1:0] EDGE = CNT_W'(bar_edge(H_ACT, k));
        assign past_edge[k] = (x >= EDGE);
    end

    always_comb begin
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (past_edge[i]) begin
                idx = 3'(i);
            end
        end
        mask  = bar_color(idx);
        color = {{R_W{mask[2]}}, {G_W{mask[1]}}, {B_W{mask[0]}}};
    end

endmodule

// File: rtl/vga_ctrl_param.sv
// Parametrised VGA timing and pixel-output controller with look-ahead pixel
// requests and a frame-synchronous colour-bar test pattern.
module vga_ctrl_param
    import vga_pkg::*;
#(
    parameter int H_SYNC  = VGA_640x480_60.h_sync,
    parameter int H_BP    = VGA_640x480_60.h_bp,
    parameter int H_ACT   = VGA_640x480_60.h_act,
    parameter int H_FP    = VGA_640x480_60.h_fp,
    parameter int V_SYNC  = VGA_640x480_60.v_sync,
    parameter int V_BP    = VGA_640x480_60.v_bp,
    parameter int V_ACT   = VGA_640x480_60.v_act,
    parameter int V_FP    = VGA_640x480_60.v_fp,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0,
    parameter int R_W     = 5,
    parameter int G_W     = 6,
    parameter int B_W     = 5,
    parameter int CNT_W   = 12,
    parameter int PIX_LAT = 1
) (
    input  logic                     vga_clk,
    input  logic                     sys_rst_n,
    input  logic [R_W+G_W+B_W-1:0]   pix_data,
    input  logic                     test_en,
    output logic                     pix_req,
    output logic [CNT_W-1:0]         pix_x,
    output logic [CNT_W-1:0]         pix_y,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic [R_W+G_W+B_W-1:0]   rgb,
    output logic                     frame_start
);

    localparam int RGB_W = R_W + G_W + B_W;
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_ST  = H_SYNC + H_BP;
    localparam int V_ST  = V_SYNC + V_BP;

    if (PIX_LAT < 0 || PIX_LAT > H_ST) begin : g_bad_pix_lat
        $error("vga_ctrl_param: PIX_LAT must lie in 0..H_SYNC+H_BP");
    end
    if (H_TOT >= 2**CNT_W || V_TOT >= 2**CNT_W) begin : g_bad_cnt_w
        $error("vga_ctrl_param: CNT_W too narrow for the timing set");
    end
    if (H_SYNC < 1 || H_ACT < 8 || V_SYNC < 1 || V_ACT < 1) begin : g_bad_timing
        $error("vga_ctrl_param: degenerate timing set");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ST_C   = CNT_W'(H_ST);
    localparam logic [CNT_W-1:0] H_END_C  = CNT_W'(H_ST + H_ACT);
    localparam logic [CNT_W-1:0] V_ST_C   = CNT_W'(V_ST);
    localparam logic [CNT_W-1:0] V_END_C  = CNT_W'(V_ST + V_ACT);
    localparam logic [CNT_W-1:0] REQ_LO_C = CNT_W'(H_ST - PIX_LAT);
    localparam logic [CNT_W-1:0] REQ_HI_C = CNT_W'(H_ST + H_ACT - PIX_LAT);
    localparam logic             HP       = (H_POL != 0);
    localparam logic             VP       = (V_POL != 0);

    logic [CNT_W-1:0] cnt_h;
    logic [CNT_W-1:0] cnt_v;
    logic             test_sel;
    logic             v_act;
    logic             active;
    logic             frame_top;
    logic [CNT_W-1:0] bar_x;
    logic [RGB_W-1:0] bar_rgb;

    assign v_act     = (cnt_v >= V_ST_C) && (cnt_v < V_END_C);
    assign active    = v_act && (cnt_h >= H_ST_C) && (cnt_h < H_END_C);
    assign frame_top = (cnt_h == '0) && (cnt_v == '0);
    assign bar_x     = cnt_h - H_ST_C;

    // Requests run PIX_LAT clocks ahead of the active window on the same line.
    assign pix_req = v_act && (cnt_h >= REQ_LO_C) && (cnt_h < REQ_HI_C);
    assign pix_x   = pix_req ? (cnt_h - REQ_LO_C) : '1;
    assign pix_y   = pix_req ? (cnt_v - V_ST_C)   : '1;

    vga_color_bar #(
        .H_ACT (H_ACT),
        .R_W   (R_W),
        .G_W   (G_W),
        .B_W   (B_W),
        .CNT_W (CNT_W)
    ) u_color_bar (
        .x     (bar_x),
        .color (bar_rgb)
    );

    // test_sel only changes at the top-left corner so a frame never mixes sources.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h       <= '0;
            cnt_v       <= '0;
            hsync       <= ~HP;
            vsync       <= ~VP;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
            test_sel    <= 1'b0;
        end else begin
            if (cnt_h == H_LAST) begin
                cnt_h <= '0;
                cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + CNT_W'(1);
            end else begin
                cnt_h <= cnt_h + CNT_W'(1);
            end
            hsync       <= (cnt_h < H_SYNC_C) ? HP : ~HP;
            vsync       <= (cnt_v < V_SYNC_C) ? VP : ~VP;
            de          <= active;
            rgb         <= active ? (test_sel ? bar_rgb : pix_data) : '0;
            frame_start <= frame_top;
            if (frame_top) begin
                test_sel <= test_en;
            end
        end
    end

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param: a small-timing instance checked every cycle against
// a frame-position model, plus polarity and default-timing instances.
module tb_vga_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: H 4/4/16/4, V 2/2/4/2, negative sync, PIX_LAT=3.
    logic        rst_a;
    logic        test_en_a;
    logic [15:0] pix_data_a;
    logic        pix_req_a;
    logic [11:0] pix_x_a, pix_y_a;
    logic        hsync_a, vsync_a, de_a, fs_a;
    logic [15:0] rgb_a;

    // Instance B: same small timing, positive sync, PIX_LAT=0.
    // Instance C: default 640x480 timing.
    logic        rst_bc;
    logic        pix_req_b, hsync_b, vsync_b, de_b, fs_b;
    logic [11:0] pix_x_b, pix_y_b;
    logic [15:0] rgb_b;
    logic        pix_req_c, hsync_c, vsync_c, de_c, fs_c;
    logic [11:0] pix_x_c, pix_y_c;
    logic [15:0] rgb_c;

    vga_ctrl_param #(
        .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4),
        .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(2),
        .PIX_LAT(3)
    ) dut_a (
        .vga_clk(clk), .sys_rst_n(rst_a), .pix_data(pix_data_a), .test_en(test_en_a),
        .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
    );

    vga_ctrl_param #(
        .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4),
        .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(2),
        .H_POL(1), .V_POL(1), .PIX_LAT(0)
    ) dut_b (
        .vga_clk(clk), .sys_rst_n(rst_bc), .pix_data(16'h0), .test_en(1'b0),
        .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .rgb(rgb_b), .frame_start(fs_b)
    );

    vga_ctrl_param dut_c (
        .vga_clk(clk), .sys_rst_n(rst_bc), .pix_data(16'h0), .test_en(1'b0),
        .pix_req(pix_req_c), .pix_x(pix_x_c), .pix_y(pix_y_c),
        .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .rgb(rgb_c), .frame_start(fs_c)
    );

    // Upstream source with 3 cycles of latency, returning {row, column}.
    logic [15:0] up_d1, up_d2, up_d3;
    always @(posedge clk) begin
        up_d1 <= {pix_y_a[7:0], pix_x_a[7:0]};
        up_d2 <= up_d1;
        up_d3 <= up_d2;
    end
    assign pix_data_a = up_d3;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bar565(input int x);
        case (x / 2)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Frame-position model of instance A: s_a is the number of clocks since release.
    int          s_a = 0;
    int          mp, mh, mv;
    logic        msel = 1'b0;
    logic        e_hs, e_vs, e_de, e_fs, e_req, m_act;
    logic [15:0] e_rgb;
    logic [11:0] e_px, e_py;

    always begin
        @(posedge clk);
        if (!rst_a) begin
            s_a = 0; msel = 1'b0;
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 16'h0; e_fs = 1'b0;
        end else begin
            mp = s_a % 280; mh = mp % 28; mv = mp / 28;
            m_act = (mh >= 8) && (mh < 24) && (mv >= 4) && (mv < 8);
            e_hs  = (mh >= 4);
            e_vs  = (mv >= 2);
            e_de  = m_act;
            e_fs  = (mp == 0);
            e_rgb = m_act ? (msel ? bar565(mh - 8) : {8'(mv - 4), 8'(mh - 8)}) : 16'h0;
            if (mp == 0) msel = test_en_a;
            s_a++;
        end
        @(negedge clk);
        if (rst_a) begin
            mp = s_a % 280; mh = mp % 28; mv = mp / 28;
            e_req = (mv >= 4) && (mv < 8) && (mh >= 5) && (mh < 21);
        end else begin
            mh = 0; mv = 0;
            e_req = 1'b0;
        end
        e_px = e_req ? 12'(mh - 5) : 12'hFFF;
        e_py = e_req ? 12'(mv - 4) : 12'hFFF;
        check_output("model_hsync", hsync_a, e_hs);
        check_output("model_vsync", vsync_a, e_vs);
        check_output("model_de", de_a, e_de);
        check_output("model_rgb", rgb_a, e_rgb);
        check_output("model_frame_start", fs_a, e_fs);
        check_output("model_pix_req", pix_req_a, e_req);
        check_output("model_pix_x", pix_x_a, e_px);
        check_output("model_pix_y", pix_y_a, e_py);
    end

    int k_a = 0;
    task automatic apply_stimulus(input int target);
        while (k_a < target) begin
            @(negedge clk);
            k_a++;
        end
    endtask

    int hs_b, vs_b, de_cnt_b, hs_c, vs_c, de_cnt_c;

    initial begin
        rst_a = 1'b0; test_en_a = 1'b0; rst_bc = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                check_output("rst_hsync", hsync_a, 1);
                check_output("rst_vsync", vsync_a, 1);
                check_output("rst_de", de_a, 0);
                check_output("rst_rgb", rgb_a, 0);
                check_output("rst_pix_x", pix_x_a, 12'hFFF);
                check_output("rst_pix_y", pix_y_a, 12'hFFF);
                #1 rst_a = 1'b1; k_a = 0;
                apply_stimulus(1);   check_output("fs_first", fs_a, 1);
                apply_stimulus(2);   check_output("fs_once", fs_a, 0);
                apply_stimulus(116); check_output("req_before", pix_req_a, 0);
                apply_stimulus(117);
                check_output("req_first", pix_req_a, 1);
                check_output("req_x0", pix_x_a, 0);
                check_output("req_y0", pix_y_a, 0);
                apply_stimulus(120); check_output("de_before", de_a, 0);
                apply_stimulus(121); check_output("de_rise", de_a, 1);
                for (int i = 0; i < 16; i++) begin
                    apply_stimulus(121 + i);
                    check_output("row0_rgb", rgb_a, i);
                end
                apply_stimulus(137); check_output("de_fall", de_a, 0);
                apply_stimulus(150);
                #1 test_en_a = 1'b1;
                apply_stimulus(180); check_output("same_frame_pix", rgb_a, 16'h0203);
                apply_stimulus(280); check_output("fs_gap", fs_a, 0);
                apply_stimulus(281); check_output("fs_period", fs_a, 1);
                apply_stimulus(401); check_output("bar_px0", rgb_a, 16'hFFFF);
                apply_stimulus(402); check_output("bar_px1", rgb_a, 16'hFFFF);
                apply_stimulus(403); check_output("bar_px2", rgb_a, 16'hFFE0);
                apply_stimulus(404); check_output("bar_px3", rgb_a, 16'hFFE0);
                apply_stimulus(413); check_output("bar_px12", rgb_a, 16'h001F);
                apply_stimulus(414); check_output("bar_px13", rgb_a, 16'h001F);
                apply_stimulus(415); check_output("bar_px14", rgb_a, 16'h0000);
                apply_stimulus(416);
                check_output("bar_px15", rgb_a, 16'h0000);
                check_output("bar_px15_de", de_a, 1);
                apply_stimulus(432);
                check_output("pre_rst_de", de_a, 1);
                check_output("pre_rst_rgb", rgb_a, 16'hFFE0);
                #1 rst_a = 1'b0;
                #1;
                check_output("async_rst_de", de_a, 0);
                check_output("async_rst_rgb", rgb_a, 0);
                check_output("async_rst_hsync", hsync_a, 1);
                repeat (2) @(negedge clk);
                #1 rst_a = 1'b1; k_a = 0;
                apply_stimulus(1);   check_output("fs_after_rst", fs_a, 1);
                apply_stimulus(2);   check_output("fs_after_rst_once", fs_a, 0);
                apply_stimulus(117); check_output("req_after_rst_x", pix_x_a, 0);
                apply_stimulus(121); check_output("bar_after_rst", rgb_a, 16'hFFFF);
                apply_stimulus(281); check_output("fs_after_rst_period", fs_a, 1);
            end
            begin
                hs_b = 0; vs_b = 0; de_cnt_b = 0; hs_c = 0; vs_c = 0; de_cnt_c = 0;
                repeat (5) @(negedge clk);
                check_output("b_rst_hsync", hsync_b, 0);
                check_output("b_rst_vsync", vsync_b, 0);
                check_output("c_rst_hsync", hsync_c, 1);
                #1 rst_bc = 1'b1;
                for (int n = 1; n <= 1600; n++) begin
                    @(negedge clk);
                    if (n <= 280) begin
                        if (hsync_b) hs_b++;
                        if (vsync_b) vs_b++;
                        if (de_b) de_cnt_b++;
                    end
                    if (!hsync_c) hs_c++;
                    if (!vsync_c) vs_c++;
                    if (de_c) de_cnt_c++;
                end
                check_output("b_hsync_high_frame", hs_b, 40);
                check_output("b_vsync_high_frame", vs_b, 56);
                check_output("b_de_frame", de_cnt_b, 64);
                check_output("c_hsync_low_2lines", hs_c, 192);
                check_output("c_vsync_low_2lines", vs_c, 1600);
                check_output("c_de_blank_rows", de_cnt_c, 0);
                @(negedge clk);
                check_output("c_vsync_release", vsync_c, 1);
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
